f1_light_seq: RTL and testbench

- Parametrised F1 start-light sequencer and reaction timer; successor to the fixed 8-light, enable-stepped light FSM.
- Lights fill one per `tick`, hold for a pseudo-random number of ticks, then go out. The block then counts clock cycles until the driver presses `react`.
- Detects a jump start (react before lights out). Drives the light bar (LED) outputs and exposes the reaction time to the display logic.

---
 rtl/f1_pkg.sv | 28 ++
 rtl/f1_lfsr.sv | 25 ++
 rtl/f1_light_seq.sv | 112 +++++++++++
 tb/tb_f1_light_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types for the F1 start-light sequencer: FSM state encoding and
// the per-width LFSR tap table.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT_UP,
    HOLD,
    TIMING,
    DONE,
    FAULT
  } f1_state_t;

  // Fibonacci tap masks for maximal-length sequences; bit n-1 set for term x^n.
  function automatic logic [7:0] lfsr_taps(input int unsigned width);
    logic [7:0] taps;
    case (width)
      4:       taps = 8'h0C; // x^4+x^3+1
      5:       taps = 8'h14; // x^5+x^3+1
      6:       taps = 8'h30; // x^6+x^5+1
      7:       taps = 8'h60; // x^7+x^6+1
      8:       taps = 8'hB8; // x^8+x^6+x^5+x^4+1
      default: taps = 8'h60;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR supplying the random hold delay.
// Shifts towards the MSB with the XOR of the tapped bits entering bit 0.
module f1_lfsr
  import f1_pkg::*;
#(
  parameter int unsigned          WIDTH = 7,
  parameter logic [WIDTH-1:0]     SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  localparam logic [7:0]       TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= SEED;
    end else begin
      out <= {out[WIDTH-2:0], ^(out & TAPS)};
    end
  end

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer and reaction timer: fills the light bar one light
// per tick, holds for a random number of ticks, then times the driver's react.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = 8,
  parameter int unsigned DELAY_W    = 7,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LFSR_SEED  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  trigger,
  input  logic                  react,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [CNT_W-1:0]      react_time,
  output logic                  time_valid,
  output logic                  jump_start,
  output logic                  busy
);

  f1_state_t          state;
  logic [DELAY_W-1:0] hold;
  logic [CNT_W-1:0]   cnt;
  logic [DELAY_W-1:0] lfsr_q;

  f1_lfsr #(
    .WIDTH (DELAY_W),
    .SEED  (DELAY_W'(LFSR_SEED))
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lights     <= '0;
      react_time <= '0;
      time_valid <= 1'b0;
      jump_start <= 1'b0;
      busy       <= 1'b0;
      hold       <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAULT: begin
          if (trigger) begin
            state      <= COUNT_UP;
            busy       <= 1'b1;
            lights     <= '0;
            time_valid <= 1'b0;
            jump_start <= 1'b0;
            cnt        <= '0;
          end
        end

        COUNT_UP: begin
          // react outranks tick so a press on a tick edge is still a jump start
          if (react) begin
            state      <= FAULT;
            busy       <= 1'b0;
            lights     <= '1;
            jump_start <= 1'b1;
          end else if (tick) begin
            if (&lights) begin
              state <= HOLD;
              hold  <= lfsr_q;
            end else begin
              lights <= {lights[NUM_LIGHTS-2:0], 1'b1};
            end
          end
        end

        HOLD: begin
          if (react) begin
            state      <= FAULT;
            busy       <= 1'b0;
            lights     <= '1;
            jump_start <= 1'b1;
          end else if (tick) begin
            if (hold == DELAY_W'(1)) begin
              state  <= TIMING;
              lights <= '0;
            end else begin
              hold <= hold - DELAY_W'(1);
            end
          end
        end

        TIMING: begin
          if (react) begin
            state      <= DONE;
            busy       <= 1'b0;
            react_time <= cnt;
            time_valid <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// Self-checking bench for f1_light_seq: directed scenarios with randomized
// timing plus a random soak, all compared against a behavioural model.
module tb_f1_light_seq;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_FILL  = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_TIME  = 3;
  localparam int PH_DONE  = 4;
  localparam int PH_FAULT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          trigger;
  logic          react;
  logic [N-1:0]  lights;
  logic [CW-1:0] react_time;
  logic          time_valid;
  logic          jump_start;
  logic          busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int  tcnt;
  bit  tick_en;
  bit  lfsr_zero;

  // behavioural model state: lit = number of lights on
  int  ph, lit, hold_left, hold_loaded, cnt, m_rt, lf;
  bit  m_tv, m_js;

  f1_light_seq #(
    .NUM_LIGHTS (N),
    .DELAY_W    (DW),
    .CNT_W      (CW),
    .LFSR_SEED  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .trigger    (trigger),
    .react      (react),
    .lights     (lights),
    .react_time (react_time),
    .time_valid (time_valid),
    .jump_start (jump_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph        <= PH_IDLE;
      lit       <= 0;
      m_rt      <= 0;
      m_tv      <= 1'b0;
      m_js      <= 1'b0;
      cnt       <= 0;
      hold_left <= 0;
      lf        <= 1;
    end else begin
      lf <= ((lf << 1) | (((lf >> 3) ^ (lf >> 2)) & 1)) & 15;
      case (ph)
        PH_IDLE, PH_DONE, PH_FAULT:
          if (trigger) begin
            ph   <= PH_FILL;
            lit  <= 0;
            m_tv <= 1'b0;
            m_js <= 1'b0;
            cnt  <= 0;
          end
        PH_FILL, PH_HOLD:
          if (react) begin
            ph   <= PH_FAULT;
            lit  <= N;
            m_js <= 1'b1;
          end else if (tick) begin
            if (ph == PH_FILL && lit < N) lit <= lit + 1;
            else if (ph == PH_FILL) begin
              ph          <= PH_HOLD;
              hold_left   <= lf;
              hold_loaded <= lf;
            end else if (hold_left == 1) begin
              ph  <= PH_TIME;
              lit <= 0;
            end else hold_left <= hold_left - 1;
          end
        PH_TIME:
          if (react) begin
            ph   <= PH_DONE;
            m_rt <= cnt;
            m_tv <= 1'b1;
          end else if (cnt < CNT_MAX) cnt <= cnt + 1;
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] obs();
    return {17'd0, lights, react_time, time_valid, jump_start, busy};
  endfunction

  function automatic logic [31:0] expv();
    logic [N-1:0] ml;
    logic         mb;
    ml = N'((1 << lit) - 1);
    mb = (ph == PH_FILL) || (ph == PH_HOLD) || (ph == PH_TIME);
    return {17'd0, ml, CW'(m_rt), m_tv, m_js, mb};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // drive one cycle of inputs, advance one edge, compare against the model
  task automatic cycle(input logic trg, input logic rct);
    trigger = trg;
    react   = rct;
    tick    = tick_en && (tcnt == 9);
    tcnt    = (tcnt == 9) ? 0 : tcnt + 1;
    @(negedge clk);
    check("outs", obs(), expv());
    check("lfsr", 32'(dut.u_lfsr.out), 32'(lf));
    if (dut.u_lfsr.out == '0) lfsr_zero = 1'b1;
  endtask

  task automatic wait_lights(input logic [N-1:0] target, input logic trg,
                             input int budget, output int ticks);
    ticks = 0;
    for (int i = 0; i < budget && lights !== target; i++) begin
      if (tick_en && tcnt == 9) ticks++;
      cycle(trg, 1'b0);
    end
    check("wait_lights", 32'(lights), 32'(target));
  endtask

  task automatic wait_tick_next();
    for (int i = 0; i < 20 && tcnt != 9; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int nt;
    rst       = 1'b1;
    tick      = 1'b0;
    trigger   = 1'b0;
    react     = 1'b0;
    tick_en   = 1'b1;
    tcnt      = 0;
    lfsr_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", obs(), 32'd0);
    check("reset_lfsr", 32'(dut.u_lfsr.out), 32'd1);
    rst = 1'b0;

    // normal fill, random hold, reaction of 37 clocks
    repeat ($urandom_range(0, 9)) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    wait_lights('1, 1'b0, 100, nt);
    check("fill_ticks", 32'(nt), 32'(N));
    wait_lights('0, 1'b0, 300, nt);
    check("hold_ticks", 32'(nt), 32'(1 + hold_loaded));
    repeat (37) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("react37_time", 32'(react_time), 32'd37);
    check("react37_valid", 32'(time_valid), 32'd1);
    check("react37_busy", 32'(busy), 32'd0);
    cycle(1'b1, 1'b0);
    check("retrigger_valid", 32'(time_valid), 32'd0);

    // jump start after the second light
    wait_lights(N'(3), 1'b0, 100, nt);
    cycle(1'b0, 1'b1);
    check("js_lights", 32'(lights), 32'hF);
    check("js_flag", 32'(jump_start), 32'd1);
    check("js_busy", 32'(busy), 32'd0);

    // react on the same edge as a tick
    cycle(1'b1, 1'b0);
    wait_tick_next();
    cycle(1'b0, 1'b1);
    check("js_tick_flag", 32'(jump_start), 32'd1);
    check("js_tick_lights", 32'(lights), 32'hF);

    // saturation, with trigger held through HOLD and TIMING
    cycle(1'b1, 1'b0);
    wait_lights('1, 1'b1, 100, nt);
    wait_lights('0, 1'b1, 300, nt);
    repeat (300) cycle(1'b1, 1'b0);
    check("sat_busy", 32'(busy), 32'd1);
    cycle(1'b0, 1'b1);
    check("sat_time", 32'(react_time), 32'(CNT_MAX));
    check("sat_valid", 32'(time_valid), 32'd1);

    // reset in the middle of HOLD
    cycle(1'b1, 1'b0);
    wait_lights('1, 1'b0, 100, nt);
    wait_tick_next();
    cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async", obs(), 32'd0);
    check("rst_model", obs(), expv());
    repeat (20) begin
      @(negedge clk);
      check("rst_held_lfsr", 32'(dut.u_lfsr.out), 32'd1);
    end
    rst = 1'b0;
    repeat (50) cycle(1'b0, 1'b0);
    check("idle_tick_lights", 32'(lights), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    lfsr_zero = 1'b0;
    repeat (1000) cycle(1'b0, 1'b0);
    check("lfsr_nonzero", 32'(lfsr_zero), 32'd0);

    // react held while entering COUNT_UP, then held trigger in FAULT
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check("held_react_js", 32'(jump_start), 32'd1);
    cycle(1'b1, 1'b0);
    check("fault_restart_busy", 32'(busy), 32'd1);
    cycle(1'b1, 1'b0);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
